// File: rtl/diffeq_mul_arbiter.sv
// diffeq_mul_arbiter
//   Shares one multi-cycle multiplier among the compute-step units of the
//   differential-equation solver. Requests are arbitrated round-robin. The
//   winner's operands are latched and the multiplier is started with a
//   one-cycle pulse. The product is returned to the winner with a one-cycle
//   resp_valid pulse. A watchdog releases the requester with a zero result and
//   sets a sticky error if the multiplier never answers.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   req         per-requester request (held until its resp_valid)
//   op_a, op_b  packed operands, requester i at [i*WIDTH +: WIDTH]
//   grant       one-hot owner of the multiplier
//   resp_valid  one-cycle pulse to the served requester
//   resp_data   product, valid while resp_valid is non-zero
//   mul_start   one-cycle multiplier start pulse
//   mul_a/mul_b latched operands driven to the multiplier
//   mul_done    multiplier completion pulse
//   mul_result  multiplier product, valid with mul_done
//   busy        high whenever the arbiter is not idle
//   error       sticky watchdog timeout flag
module diffeq_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       resp_valid,
  output logic [2*WIDTH-1:0]    resp_data,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic                  mul_done,
  input  logic [2*WIDTH-1:0]    mul_result,
  output logic                  busy,
  output logic                  error
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   g;
  logic [CW-1:0]   cnt;

  logic            found;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] win_onehot;
  int              idx;

  // Round-robin search starting at ptr; the first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign win_onehot[gi] = (win == PW'(gi));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      g          <= '0;
      cnt        <= '0;
      grant      <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A stray mul_done here is simply not looked at.
          if (found) begin
            g         <= win;
            mul_a     <= op_a[int'(win)*WIDTH +: WIDTH];
            mul_b     <= op_b[int'(win)*WIDTH +: WIDTH];
            grant     <= win_onehot;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // mul_done during the start cycle belongs to nothing we issued.
          mul_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            resp_data  <= mul_result;
            resp_valid <= grant;
            state      <= RESPOND;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Release the requester with a zero product so the solver moves on.
            error      <= 1'b1;
            resp_data  <= '0;
            resp_valid <= grant;
            state      <= RESPOND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESPOND: begin
          resp_valid <= '0;
          grant      <= '0;
          busy       <= 1'b0;
          ptr        <= (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_diffeq_mul_arbiter.sv
// Self-checking bench for diffeq_mul_arbiter: directed scenarios from the
// test plan followed by randomized transactions, checked against a
// transaction-level model (round-robin pointer, product, sticky error).
module tb_diffeq_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       resp_valid;
  logic [2*WIDTH-1:0]    resp_data;
  logic                  mul_start;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    mul_result;
  logic                  busy;
  logic                  error;

  diffeq_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
    .grant(grant), .resp_valid(resp_valid), .resp_data(resp_data),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int          m_ptr  = 0;
  logic        m_err  = 1'b0;
  logic [31:0] m_data = '0;
  logic [15:0] opa[4];
  logic [15:0] opb[4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; mul_done = 1'b0; mul_result = '0; op_a = '0; op_b = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    m_ptr = 0; m_err = 1'b0; m_data = '0;
  endtask

  task automatic idle_cycles(input int n);
    req = '0;
    repeat (n) tick();
    check("idle_busy", busy, 1'b0);
    check("idle_grant", grant, 4'b0000);
  endtask

  // One full transaction. lat = WAIT cycles before mul_done (>= TIMEOUT means never).
  task automatic run_txn(input logic [3:0] mask, input int lat, input bit stray,
                         input bit drop, input bit scramble);
    int w;
    int nwait;
    bit to;
    logic [31:0] exp_p;
    logic [3:0] oh;
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && mask[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i*WIDTH +: WIDTH] = opa[i];
      op_b[i*WIDTH +: WIDTH] = opb[i];
    end
    exp_p = 32'(opa[w]) * 32'(opb[w]);
    oh    = 4'b0001 << w;
    req   = mask;
    tick();
    check("grant", grant, oh);
    check("mul_start", mul_start, 1'b1);
    check("mul_a", mul_a, opa[w]);
    check("mul_b", mul_b, opb[w]);
    check("busy", busy, 1'b1);
    if (drop) req[w] = 1'b0;
    if (scramble) begin
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
    end
    if (stray) begin
      mul_done = 1'b1;
      mul_result = 32'h0000_DEAD;
    end
    tick();
    mul_done = 1'b0;
    check("start_pulse", mul_start, 1'b0);
    to    = (lat >= TIMEOUT);
    nwait = to ? TIMEOUT : lat + 1;
    for (int j = 0; j < nwait; j++) begin
      check("rv_wait", resp_valid, 4'b0000);
      if (!to && j == lat) begin
        mul_done   = 1'b1;
        mul_result = {16'b0, mul_a} * {16'b0, mul_b};
      end
      tick();
      mul_done = 1'b0;
    end
    if (to) m_err = 1'b1;
    m_data = to ? 32'h0 : exp_p;
    check("resp_valid", resp_valid, oh);
    check("resp_data", resp_data, m_data);
    check("error", error, m_err);
    check("grant_hold", grant, oh);
    tick();
    check("rv_clear", resp_valid, 4'b0000);
    check("grant_clear", grant, 4'b0000);
    check("busy_low", busy, 1'b0);
    check("data_hold", resp_data, m_data);
    m_ptr = (w + 1) % NREQ;
    $display("txn req=%b winner=%0d lat=%0d stray=%0d data=%h err=%0d",
             mask, w, lat, stray, m_data, m_err);
  endtask

  initial begin
    reset = 1'b1; req = '0; op_a = '0; op_b = '0; mul_done = 1'b0; mul_result = '0;
    for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
    tick();
    check("rst_grant", grant, 4'b0000);
    check("rst_resp_valid", resp_valid, 4'b0000);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_mul_start", mul_start, 1'b0);
    check("rst_mul_a", mul_a, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    do_reset();
    idle_cycles(3);

    // Single request: 3*5
    opa[0] = 16'd3; opb[0] = 16'd5;
    run_txn(4'b0001, 3, 1'b0, 1'b0, 1'b0);

    // Fairness: all requesting, order 0,1,2,3,0 from a fresh pointer
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NREQ; i++) begin opa[i] = 16'($urandom); opb[i] = 16'($urandom); end
      run_txn(4'b1111, 1 + r, 1'b0, 1'b0, 1'b0);
    end

    // Pointer wrap: serve 2, then 0101 must go to 0
    opa[2] = 16'd7; opb[2] = 16'd9;
    run_txn(4'b0100, 2, 1'b0, 1'b0, 1'b0);
    opa[0] = 16'd100; opb[0] = 16'd200; opa[2] = 16'd11; opb[2] = 16'd13;
    run_txn(4'b0101, 0, 1'b0, 1'b0, 1'b0);

    // Stray done in ISSUE, real done three cycles later with 0x42
    opa[1] = 16'd6; opb[1] = 16'd11;
    run_txn(4'b0010, 2, 1'b1, 1'b0, 1'b0);

    // Timeout, then a normal transaction with error still set
    opa[3] = 16'hFFFF; opb[3] = 16'hFFFF;
    run_txn(4'b1000, 1000, 1'b0, 1'b0, 1'b0);
    opa[0] = 16'd12; opb[0] = 16'd12;
    run_txn(4'b0001, 4, 1'b0, 1'b0, 1'b0);

    // Reset two cycles after mul_start, then a late done in IDLE
    opa[1] = 16'd5; opb[1] = 16'd5;
    op_a = '0; op_b = '0;
    op_a[WIDTH +: WIDTH] = opa[1]; op_b[WIDTH +: WIDTH] = opb[1];
    req = 4'b0010;
    tick();
    check("wr_start", mul_start, 1'b1);
    req = '0;
    tick();
    tick();
    #1 reset = 1'b1;
    #1;
    check("wr_grant", grant, 4'b0000);
    check("wr_busy", busy, 1'b0);
    check("wr_mul_a", mul_a, 16'h0);
    check("wr_error", error, 1'b0);
    reset = 1'b0;
    m_ptr = 0; m_err = 1'b0; m_data = '0;
    tick();
    mul_done = 1'b1; mul_result = 32'h1234;
    tick();
    mul_done = 1'b0;
    check("late_done_rv", resp_valid, 4'b0000);
    check("late_done_busy", busy, 1'b0);
    check("late_done_data", resp_data, 32'h0);
    tick();
    check("late_done_rv2", resp_valid, 4'b0000);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin opa[i] = 16'($urandom); opb[i] = 16'($urandom); end
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 8),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
